// File: rtl/mac_pkg.sv
// Shared definitions for the multiply/accumulate datapath: rounding-mode
// encodings and the rounding decision used by both the multiplier and adder paths.
package mac_pkg;

    typedef enum logic [1:0] {
        RND_TRUNC   = 2'd0,
        RND_HALF_UP = 2'd1,
        RND_RNE     = 2'd2
    } rnd_mode_e;

    // half: first discarded bit; sticky: OR of the discarded bits below it;
    // lsb: LSB of the kept field. Encoding 3 behaves as truncate.
    function automatic logic round_up(input logic [1:0] mode,
                                      input logic       half,
                                      input logic       sticky,
                                      input logic       lsb);
        logic up;
        case (mode)
            RND_HALF_UP: up = half;
            RND_RNE:     up = half & (sticky | lsb);
            default:     up = 1'b0;
        endcase
        return up;
    endfunction

endpackage

// File: rtl/mul_man_pp.sv
// Combinational partial-product generator: op2 is split at SPLIT, and each
// half is multiplied by op1 at the width its product needs.
module mul_man_pp #(
    parameter int MAN_W = 12,
    parameter int SPLIT = 5
) (
    input  logic [MAN_W-1:0]         op1,
    input  logic [MAN_W-1:0]         op2,
    output logic [MAN_W+SPLIT-1:0]   pp_lo,
    output logic [2*MAN_W-SPLIT-1:0] pp_hi
);

    localparam int LO_W = MAN_W + SPLIT;
    localparam int HI_W = 2 * MAN_W - SPLIT;

    assign pp_lo = LO_W'(op1) * LO_W'(op2[SPLIT-1:0]);
    assign pp_hi = HI_W'(op1) * HI_W'(op2[MAN_W-1:SPLIT]);

endmodule

// File: rtl/mul_man_pipe.sv
// Two-stage mantissa multiplier: stage 1 holds the partial products, stage 2
// holds the product's upper OUT_W bits rounded per the captured mode.
module mul_man_pipe
    import mac_pkg::*;
#(
    parameter int MAN_W = 12,
    parameter int OUT_W = 16,
    parameter int SPLIT = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAN_W-1:0] op1,
    input  logic [MAN_W-1:0] op2,
    input  logic [1:0]       rnd_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] result,
    output logic             inexact
);

    localparam int P_W  = 2 * MAN_W;
    localparam int DW   = P_W - OUT_W;
    localparam int LO_W = MAN_W + SPLIT;
    localparam int HI_W = P_W - SPLIT;

    if (OUT_W < MAN_W || OUT_W > P_W || SPLIT < 1 || SPLIT >= MAN_W) begin : g_bad_param
        $fatal(1, "mul_man_pipe: illegal MAN_W/OUT_W/SPLIT combination");
    end

    logic [LO_W-1:0]  w_pp_lo;
    logic [HI_W-1:0]  w_pp_hi;
    logic             w_s1_load;
    logic             w_s2_load;
    logic [P_W-1:0]   w_prod;
    logic [OUT_W-1:0] w_trunc;
    logic             w_round_up;
    logic             w_inexact;

    logic             r_s1_valid;
    logic [LO_W-1:0]  r_pp_lo;
    logic [HI_W-1:0]  r_pp_hi;
    logic [1:0]       r_s1_rnd;
    logic             r_s2_valid;
    logic [OUT_W-1:0] r_result;
    logic             r_inexact;

    mul_man_pp #(.MAN_W(MAN_W), .SPLIT(SPLIT)) u_pp (
        .op1   (op1),
        .op2   (op2),
        .pp_lo (w_pp_lo),
        .pp_hi (w_pp_hi)
    );

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;
    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign inexact   = r_inexact;

    // Recombine the partial products into the full product and its kept field.
    always_comb begin
        w_prod  = P_W'(r_pp_lo) + (P_W'(r_pp_hi) << SPLIT);
        w_trunc = w_prod[P_W-1:DW];
    end

    if (DW == 0) begin : g_exact
        assign w_round_up = 1'b0;
        assign w_inexact  = 1'b0;
    end else begin : g_round
        localparam logic [DW-1:0] STICKY_MASK = {DW{1'b1}} >> 1;
        logic [DW-1:0] w_disc;

        // Rounding decision from the discarded field and the kept LSB.
        always_comb begin
            w_disc     = w_prod[DW-1:0];
            w_inexact  = |w_disc;
            w_round_up = round_up(r_s1_rnd, w_disc[DW-1], |(w_disc & STICKY_MASK), w_trunc[0]);
        end
    end

    // Stage 1: capture partial products and rounding mode on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_pp_lo    <= '0;
            r_pp_hi    <= '0;
            r_s1_rnd   <= 2'd0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_pp_lo  <= w_pp_lo;
                r_pp_hi  <= w_pp_hi;
                r_s1_rnd <= rnd_mode;
            end
        end
    end

    // Stage 2: rounded result; data only moves when a valid item arrives so a stall holds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_inexact  <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result  <= w_trunc + OUT_W'(w_round_up);
                r_inexact <= w_inexact;
            end
        end
    end

endmodule

// File: doc/mul_man_pipe.md
MUL_MAN_PIPE -- requirements
Module: mul_man_pipe

Interface
REQ-001 SHALL have parameter MAN_W, default 12: operand mantissa width, including the hidden bit.
REQ-002 SHALL have parameter OUT_W, default 16: result width (upper product bits); legal range MAN_W <= OUT_W <= 2*MAN_W.
REQ-003 SHALL have parameter SPLIT, default 5: op2 split point for the partial products; legal range 1 <= SPLIT < MAN_W.
REQ-004 SHALL have port clk  input  1  clock, all flops rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  operands present.
REQ-007 SHALL have port in_ready  output  1  operands accepted when in_valid & in_ready.
REQ-008 SHALL have port op1  input  MAN_W  unsigned multiplicand.
REQ-009 SHALL have port op2  input  MAN_W  unsigned multiplier.
REQ-010 SHALL have port rnd_mode  input  2  0 truncate, 1 round-half-up, 2 round-nearest-even, 3 treated as truncate.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  result consumed when out_valid & out_ready.
REQ-013 SHALL have port result  output  OUT_W  rounded upper OUT_W bits of op1*op2.
REQ-014 SHALL have port inexact  output  1  at least one discarded product bit is nonzero.

Function
REQ-015 SHALL compute the full product P = op1*op2, 2*MAN_W bits, and the discarded field D = P[2*MAN_W-OUT_W-1:0].
REQ-016 Stage 1 SHALL register pp_lo = op1*op2[SPLIT-1:0], pp_hi = op1*op2[MAN_W-1:SPLIT], and rnd_mode, plus a valid bit.
REQ-017 Stage 2 SHALL register P = pp_lo + (pp_hi << SPLIT), rounded per the stage-1 rnd_mode, plus a valid bit.
REQ-018 Truncate SHALL output P's upper OUT_W bits unchanged.
REQ-019 Half-up SHALL add 1 when D's MSB is 1.
REQ-020 RNE SHALL add 1 when D's MSB is 1 and (the remaining D bits are nonzero or the result LSB is 1).
REQ-021 The rounding increment SHALL never overflow OUT_W; this is guaranteed by REQ-002 and needs no carry-out port.
REQ-022 When OUT_W == 2*MAN_W, D SHALL be empty, inexact SHALL be 0, and all modes SHALL be equal.
REQ-023 Latency SHALL be exactly 2 cycles from accept to out_valid when out_ready stays 1.
REQ-024 Throughput SHALL be 1 result/cycle.
REQ-025 Stage 2 SHALL load when it is empty or out_ready=1.
REQ-026 Stage 1 SHALL load when it is empty or stage 2 loads.
REQ-027 in_ready SHALL equal the stage-1 load condition; it is combinational from out_ready, with no dependence on in_valid.
REQ-028 While stalled (out_valid=1, out_ready=0), result and inexact SHALL hold stable.
REQ-029 No result SHALL be lost, duplicated or reordered.
REQ-030 On a simultaneous out accept and in accept with full stages, both stages SHALL shift in the same cycle.
REQ-031 Operands of zero SHALL give result 0 and inexact 0 in every mode.

Reset
REQ-032 On rst_n low, both valid bits SHALL clear immediately: out_valid=0, in_ready=1.
REQ-033 On rst_n low, all data registers SHALL clear to 0: result=0, inexact=0.
REQ-034 In-flight operations SHALL be discarded on reset mid-operation.
REQ-035 The first accept after rst_n deasserts SHALL be honoured on the first rising edge.

Structure
REQ-036 Rounding-mode encodings (RND_TRUNC, RND_HALF_UP, RND_RNE) SHALL live in shared package mac_pkg, reused by the adder path.
REQ-037 Partial-product generation SHALL be a combinational sub-module mul_man_pp (op1, op2 -> pp_lo, pp_hi), parameterised by MAN_W and SPLIT.
REQ-038 Parameter legality SHALL be checked at elaboration; an illegal value is a fatal error.

Verification (MAN_W=12, OUT_W=16, SPLIT=5)
REQ-039 op1=0xFFF, op2=0xFFF, any mode -> result 0xFFE0 and inexact 1, 2 cycles after accept.
REQ-040 op1=0x010, op2=0x008 (P=0x80) -> truncate 0x0000, half-up 0x0001, RNE 0x0000; inexact 1 in all three.
REQ-041 op1=0x018, op2=0x010 (P=0x180) -> truncate 0x0001, half-up 0x0002, RNE 0x0002; op1=0x100, op2=0x100 -> 0x0100 with inexact 0.
REQ-042 Stream of 6 back-to-back inputs with out_ready held 0 for cycles 3-5 -> in_ready falls once both stages are full; all 6 results emerge in order, values stable while stalled.
REQ-043 Assert rst_n low with two operations in flight -> out_valid=0 and result=0 immediately; no stale result after release.
REQ-044 Random operands and modes with random out_ready -> every result matches a reference model of REQ-015..REQ-020; also run with OUT_W=24 (inexact always 0).
